// File: rtl/rs_multi.sv
`default_nettype none
// =============================================================================
// Module   : rs_multi
// Brief    : Reservation station with NUM_CDB wakeup channels and a valid/ready
//            issue register. Macro RS_OLDEST_FIRST_EN selects ROB-age ordering,
//            otherwise the lowest-index ready entry issues.
// Revision : 1.0  initial release
// =============================================================================
module rs_multi #(
    parameter int DEPTH   = 8,
    parameter int XLEN    = 32,
    parameter int ID_W    = 4,
    parameter int OP_W    = 6,
    parameter int NUM_CDB = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [OP_W-1:0]             disp_op,
    input  logic [ID_W-1:0]             disp_id,
    input  logic                        disp_q1_pend,
    input  logic                        disp_q2_pend,
    input  logic [ID_W-1:0]             disp_q1,
    input  logic [ID_W-1:0]             disp_q2,
    input  logic [XLEN-1:0]             disp_v1,
    input  logic [XLEN-1:0]             disp_v2,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ID_W-1:0]     cdb_id,
    input  logic [NUM_CDB*XLEN-1:0]     cdb_data,
    input  logic [ID_W-1:0]             rob_head,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [OP_W-1:0]             iss_op,
    output logic [XLEN-1:0]             iss_v1,
    output logic [XLEN-1:0]             iss_v2,
    output logic [ID_W-1:0]             iss_id,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic              r_busy [DEPTH];
    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [ID_W-1:0]   r_id   [DEPTH];
    logic              r_p1   [DEPTH];
    logic              r_p2   [DEPTH];
    logic [ID_W-1:0]   r_q1   [DEPTH];
    logic [ID_W-1:0]   r_q2   [DEPTH];
    logic [XLEN-1:0]   r_v1   [DEPTH];
    logic [XLEN-1:0]   r_v2   [DEPTH];
    logic              r_iss_valid;
    logic [OP_W-1:0]   r_iss_op;
    logic [XLEN-1:0]   r_iss_v1;
    logic [XLEN-1:0]   r_iss_v2;
    logic [ID_W-1:0]   r_iss_id;
    logic [c_cnt_w-1:0] r_count;

    logic [XLEN:0]        w_s1 [DEPTH];
    logic [XLEN:0]        w_s2 [DEPTH];
    logic [XLEN:0]        w_d1;
    logic [XLEN:0]        w_d2;
    logic [DEPTH-1:0]     w_elig;
    logic [c_idx_w-1:0]   w_free;
    logic [c_idx_w-1:0]   w_sel;
    logic                 w_any_elig;
    logic                 w_load;
    logic                 w_issue;
    logic                 w_disp;

    // Returns {hit, data}; the descending scan lets the lowest channel win.
    function automatic logic [XLEN:0] f_snoop(
        input logic [ID_W-1:0]         q,
        input logic [NUM_CDB-1:0]      v,
        input logic [NUM_CDB*ID_W-1:0] ids,
        input logic [NUM_CDB*XLEN-1:0] data
    );
        logic [XLEN:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (v[k] && (ids[k*ID_W +: ID_W] == q)) res = {1'b1, data[k*XLEN +: XLEN]};
        end
        return res;
    endfunction

    always_comb begin
        w_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_elig[i] = r_busy[i] && !r_p1[i] && !r_p2[i];
            w_s1[i]   = f_snoop(r_q1[i], cdb_valid, cdb_id, cdb_data);
            w_s2[i]   = f_snoop(r_q2[i], cdb_valid, cdb_id, cdb_data);
            if (!r_busy[i]) w_free = c_idx_w'(i);
        end
        w_d1 = f_snoop(disp_q1, cdb_valid, cdb_id, cdb_data);
        w_d2 = f_snoop(disp_q2, cdb_valid, cdb_id, cdb_data);
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [ID_W-1:0] w_age [DEPTH];
    logic [ID_W-1:0] w_best;

    // Age is distance from the ROB head, so wrapped ids still order correctly.
    always_comb begin
        w_any_elig = 1'b0;
        w_sel      = '0;
        w_best     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_age[i] = r_id[i] - rob_head;
            if (w_elig[i] && (!w_any_elig || (w_age[i] < w_best))) begin
                w_any_elig = 1'b1;
                w_sel      = c_idx_w'(i);
                w_best     = w_age[i];
            end
        end
    end
`else
    logic w_unused_head;
    assign w_unused_head = ^rob_head;

    always_comb begin
        w_any_elig = |w_elig;
        w_sel      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) w_sel = c_idx_w'(i);
        end
    end
`endif

    assign disp_ready = (r_count != c_full);
    assign w_load     = !r_iss_valid || iss_ready;
    assign w_issue    = w_load && w_any_elig;
    assign w_disp     = disp_valid && disp_ready;

    assign iss_valid = r_iss_valid;
    assign iss_op    = r_iss_op;
    assign iss_v1    = r_iss_v1;
    assign iss_v2    = r_iss_v2;
    assign iss_id    = r_iss_id;
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_op[i]   <= '0;
                r_id[i]   <= '0;
                r_p1[i]   <= 1'b0;
                r_p2[i]   <= 1'b0;
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
            end
            r_iss_valid <= 1'b0;
            r_iss_op    <= '0;
            r_iss_v1    <= '0;
            r_iss_v2    <= '0;
            r_iss_id    <= '0;
            r_count     <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) r_busy[i] <= 1'b0;
                r_iss_valid <= 1'b0;
                r_count     <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_busy[i] && r_p1[i] && w_s1[i][XLEN]) begin
                        r_p1[i] <= 1'b0;
                        r_v1[i] <= w_s1[i][XLEN-1:0];
                    end
                    if (r_busy[i] && r_p2[i] && w_s2[i][XLEN]) begin
                        r_p2[i] <= 1'b0;
                        r_v2[i] <= w_s2[i][XLEN-1:0];
                    end
                end

                if (w_issue) begin
                    r_busy[w_sel] <= 1'b0;
                    r_iss_valid   <= 1'b1;
                    r_iss_op      <= r_op[w_sel];
                    r_iss_v1      <= r_v1[w_sel];
                    r_iss_v2      <= r_v2[w_sel];
                    r_iss_id      <= r_id[w_sel];
                end else if (w_load) begin
                    r_iss_valid <= 1'b0;
                end

                // The free slot comes from registered busy bits, so it never aliases the issuing slot.
                if (w_disp) begin
                    r_busy[w_free] <= 1'b1;
                    r_op[w_free]   <= disp_op;
                    r_id[w_free]   <= disp_id;
                    r_q1[w_free]   <= disp_q1;
                    r_q2[w_free]   <= disp_q2;
                    r_p1[w_free]   <= disp_q1_pend && !w_d1[XLEN];
                    r_p2[w_free]   <= disp_q2_pend && !w_d2[XLEN];
                    r_v1[w_free]   <= (disp_q1_pend && w_d1[XLEN]) ? w_d1[XLEN-1:0] : disp_v1;
                    r_v2[w_free]   <= (disp_q2_pend && w_d2[XLEN]) ? w_d2[XLEN-1:0] : disp_v2;
                end

                case ({w_disp, w_issue})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
